tdm_demux_1to8: RTL and testbench
=================================

Name: tdm_demux_1to8

Overview:
- Sequential 1-to-N time-division demultiplexer; the receive-side counterpart of the team's 8:1 mux.
- Upstream, the mux serialises channel d[k] onto y while its select steps 0..N_CH-1. This block takes that serial stream plus a start-of-frame marker and rebuilds the parallel word.
- Presents the rebuilt word on dout with a one-cycle frame_valid strobe.
- Sits between the serial link and any parallel consumer.

Parameters:
- N_CH, 8, number of channels (slots) per frame; must be at least 2.
- DATA_W, 1, width of each channel sample.
- SEL_W, $clog2(N_CH), slot index width (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  din/sof qualify on this cycle.
- sof  input  1  start of frame; marks din as slot 0; ignored unless in_valid.
- din  input  DATA_W  serial channel sample.
- dout  output  N_CH*DATA_W  last complete frame; slot k occupies dout[k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse: dout was just updated.
- frame_err  output  1  one-cycle pulse: partial frame aborted by an early sof.
- slot  output  SEL_W  next slot index to be filled (debug/monitor).

Behaviour:
- Reset (async assert, sync-released by the system) and its effect on outputs:
  - dout=0, frame_valid=0, frame_err=0, slot=0, state=IDLE, shadow register=0.
  - Reset mid-frame discards the partial frame; dout returns to 0.
- States are IDLE and COLLECT.
- IDLE:
  - in_valid && sof: shadow[0] <= din, slot <= 1, go to COLLECT.
  - in_valid && !sof: sample dropped, no error, stay in IDLE.
- COLLECT, on in_valid && !sof:
  - shadow[slot] <= din.
  - If slot < N_CH-1: slot <= slot+1.
  - If slot == N_CH-1: dout <= {din, shadow[N_CH-2:0]} (the final sample goes straight to dout), frame_valid <= 1, slot <= 0, go to IDLE.
- COLLECT, on in_valid && sof (early sof):
  - frame_err <= 1 for one cycle; partial frame discarded; dout unchanged.
  - The new sample is taken as slot 0 of a new frame: shadow[0] <= din, slot <= 1, stay in COLLECT.
- in_valid low: everything holds; there is no timeout and gaps of any length are allowed.
- Latency: dout and frame_valid update on the same edge that captures slot N_CH-1, so they are visible one cycle after the final sample is presented.
- frame_valid and frame_err are registered and deasserted on the next edge. They never assert together.
- Back-to-back frames: a sof on the cycle right after the final slot is accepted with no bubble, since the FSM is already in IDLE.
- Between completed frames dout holds its value.
- slot wraps only through the completion path; it never exceeds N_CH-1.

Decomposition:
- Package tdm_pkg holds:
  - the state enum (IDLE, COLLECT);
  - default N_CH and DATA_W constants;
  - helper function slot_w(n) = $clog2(n).
- One sub-module, tdm_slot_counter:
  - inputs: clk, rst_n, load0 (sof), inc, clr;
  - outputs: slot and last (slot == N_CH-1).
- The FSM and the shadow/dout registers stay in the top level.

Test Plan:
- Basic frame, N_CH=8, DATA_W=1: a single frame with sof on the first beat. Serial order is dout[0]..dout[7].
  - Stimulus: din sequence 1,0,1,0,1,0,0,1 on 8 consecutive in_valid cycles.
  - Response: dout=8'h95 and frame_valid high for exactly one cycle, one cycle after the 8th beat; frame_err=0.
- Gapped input: same frame with in_valid low for 3 cycles between slots 3 and 4.
  - Response: dout=8'h95, frame_valid once; slot holds at 4 during the gap.
- Early sof:
  - Stimulus: sof, then 4 beats, then a sof with din=1, then 7 beats 1,1,1,1,1,1,1.
  - Response: frame_err pulses once at the second sof; dout=8'hFF after completion; no frame_valid for the aborted frame.
- Back-to-back frames:
  - Stimulus: frame 8'h95, then on the next cycle a sof starting frame 8'h3C.
  - Response: two frame_valid pulses 8 cycles apart; dout=8'h95, then 8'h3C.
- Reset behaviour:
  - Stimulus: rst_n asserted low after 5 beats, released, then a full frame 8'hA5.
  - Response: during reset all outputs are 0 immediately, without waiting for a clock edge. After the frame, dout=8'hA5 with a single frame_valid.
- IDLE filtering: 6 in_valid beats without sof in IDLE.
  - Response: slot stays 0, no frame_valid, no frame_err, dout unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer slice.
package tdm_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } tdm_state_e;

  localparam int unsigned NChDefault   = 8;
  localparam int unsigned DataWDefault = 1;

  function automatic int unsigned slot_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear to 0, load to 1 on start of frame, or step by one.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH  = NChDefault,
  parameter int unsigned SEL_W = slot_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load0,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             last
);

  logic [SEL_W-1:0] slot_q, slot_d;

  // load0 means slot 0 was just captured, so the next slot to fill is 1
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load0) begin
      slot_d = SEL_W'(1);
    end else if (inc) begin
      slot_d = slot_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SEL_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux_1to8.sv
// 1-to-N TDM demultiplexer: rebuilds a parallel word from a serial slot stream marked by sof.
module tdm_demux_1to8
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH   = NChDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned SEL_W = slot_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   sof,
  input  logic [DATA_W-1:0]      din,
  output logic [N_CH*DATA_W-1:0] dout,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [SEL_W-1:0]       slot
);

  tdm_state_e                         state_q;
  logic       [N_CH-1:0][DATA_W-1:0]  shadow_q;
  logic       [N_CH*DATA_W-1:0]       dout_q;
  logic                               frame_valid_q;
  logic                               frame_err_q;
  logic                               cnt_load0, cnt_inc, cnt_clr, cnt_last;
  logic       [SEL_W-1:0]             cnt_slot;
  logic                               beat;

  assign beat = in_valid && !sof && (state_q == StCollect);

  always_comb begin
    cnt_load0 = in_valid && sof;
    cnt_inc   = beat && !cnt_last;
    cnt_clr   = beat && cnt_last;
  end

  tdm_slot_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load0 (cnt_load0),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .slot  (cnt_slot),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          StIdle: begin
            // Beats without sof are dropped silently while waiting for a frame
            if (sof) begin
              shadow_q[0] <= din;
              state_q     <= StCollect;
            end
          end
          StCollect: begin
            if (sof) begin
              frame_err_q <= 1'b1;
              shadow_q[0] <= din;
            end else begin
              shadow_q[cnt_slot] <= din;
              if (cnt_last) begin
                // Final sample bypasses the shadow so dout lands on this edge
                dout_q        <= {din, shadow_q[N_CH-2:0]};
                frame_valid_q <= 1'b1;
                state_q       <= StIdle;
              end
            end
          end
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign slot        = cnt_slot;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Self-checking bench for tdm_demux_1to8 against a queue-based frame model.
module tb_tdm_demux_1to8;

  localparam int N = 8;
  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           sof = 1'b0;
  logic [W-1:0]   din = '0;
  logic [N*W-1:0] dout;
  logic           frame_valid;
  logic           frame_err;
  logic [2:0]     slot;

  tdm_demux_1to8 #(
    .N_CH   (N),
    .DATA_W (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .sof         (sof),
    .din         (din),
    .dout        (dout),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a frame in progress is just the list of samples received since its sof.
  bit             collecting = 0;
  logic [W-1:0]   samples[$];
  logic [N*W-1:0] m_dout = '0;
  bit             m_fv = 0;
  bit             m_fe = 0;
  int             m_slot = 0;
  int             fv_cnt = 0;
  int             fe_cnt = 0;
  int             cyc = 0;
  int             fv_cyc_prev = 0;
  int             fv_cyc_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    logic         s_iv, s_sof;
    logic [W-1:0] s_din;
    @(posedge clk);
    cyc++;
    s_iv  = in_valid;
    s_sof = sof;
    s_din = din;
    if (!rst_n) begin
      collecting = 0;
      samples.delete();
      m_dout = '0;
      m_fv   = 0;
      m_fe   = 0;
      m_slot = 0;
    end else begin
      m_fv = 0;
      m_fe = 0;
      if (s_iv) begin
        if (s_sof) begin
          if (collecting) m_fe = 1;
          samples.delete();
          samples.push_back(s_din);
          collecting = 1;
        end else if (collecting) begin
          samples.push_back(s_din);
          if (samples.size() == N) begin
            for (int k = 0; k < N; k++) m_dout[k*W +: W] = samples[k];
            m_fv = 1;
            collecting = 0;
            samples.delete();
          end
        end
      end
      m_slot = collecting ? samples.size() : 0;
    end
    #1;
    chk("dout", 64'(dout), 64'(m_dout));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("frame_err", 64'(frame_err), 64'(m_fe));
    chk("slot", 64'(slot), 64'(m_slot));
    if (rst_n && frame_valid === 1'b1) begin
      fv_cnt++;
      fv_cyc_prev = fv_cyc_last;
      fv_cyc_last = cyc;
    end
    if (rst_n && frame_err === 1'b1) fe_cnt++;
  end

  task automatic beat(input bit s, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    sof      = s;
    din      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      sof      = 1'b0;
      din      = '0;
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input int gap_after, input int gap_len);
    for (int k = 0; k < N; k++) begin
      beat(k == 0, v[k]);
      if (k == gap_after) begin
        idle(gap_len);
        chk("gap_slot_hold", 64'(slot), 64'd4);
      end
    end
  endtask

  int fv0, fe0;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_dout", 64'(dout), 64'h0);
    chk("reset_slot", 64'(slot), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame 1,0,1,0,1,0,0,1 -> 8'h95
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame(8'h95, -1, 0);
    idle(2);
    chk("basic_model", 64'(m_dout), 64'h95);
    chk("basic_dout", 64'(dout), 64'h95);
    chk("basic_fv_cnt", 64'(fv_cnt - fv0), 64'd1);
    chk("basic_fe_cnt", 64'(fe_cnt - fe0), 64'd0);

    // Gapped frame: 3 idle cycles between slots 3 and 4
    fv0 = fv_cnt;
    send_frame(8'h95, 3, 3);
    idle(2);
    chk("gap_dout", 64'(dout), 64'h95);
    chk("gap_fv_cnt", 64'(fv_cnt - fv0), 64'd1);

    // Early sof: aborted partial frame, then seven ones after a sof with din=1
    fv0 = fv_cnt; fe0 = fe_cnt;
    beat(1, 1'b0);
    repeat (4) beat(0, 1'b0);
    beat(1, 1'b1);
    repeat (7) beat(0, 1'b1);
    idle(2);
    chk("early_fe_cnt", 64'(fe_cnt - fe0), 64'd1);
    chk("early_fv_cnt", 64'(fv_cnt - fv0), 64'd1);
    chk("early_dout", 64'(dout), 64'hFF);

    // Back-to-back frames with no bubble
    fv0 = fv_cnt;
    send_frame(8'h95, -1, 0);
    send_frame(8'h3C, -1, 0);
    idle(2);
    chk("b2b_fv_cnt", 64'(fv_cnt - fv0), 64'd2);
    chk("b2b_spacing", 64'(fv_cyc_last - fv_cyc_prev), 64'd8);
    chk("b2b_dout", 64'(dout), 64'h3C);

    // Reset mid-frame: outputs clear asynchronously
    beat(1, 1'b1);
    repeat (4) beat(0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 64'(dout), 64'h0);
    chk("async_rst_slot", 64'(slot), 64'h0);
    chk("async_rst_fv", 64'(frame_valid), 64'h0);
    chk("async_rst_fe", 64'(frame_err), 64'h0);
    idle(2);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    send_frame(8'hA5, -1, 0);
    idle(2);
    chk("post_rst_dout", 64'(dout), 64'hA5);
    chk("post_rst_fv_cnt", 64'(fv_cnt - fv0), 64'd1);

    // IDLE filtering: beats without sof are ignored
    fv0 = fv_cnt; fe0 = fe_cnt;
    for (int k = 0; k < 6; k++) beat(0, 1'(k));
    idle(1);
    chk("idle_slot", 64'(slot), 64'h0);
    chk("idle_dout", 64'(dout), 64'hA5);
    chk("idle_fv_cnt", 64'(fv_cnt - fv0), 64'd0);
    chk("idle_fe_cnt", 64'(fe_cnt - fe0), 64'd0);

    // Random traffic: gaps, stray beats, early sofs, full frames
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      sof      = ($urandom_range(0, 9) == 0);
      din      = W'($urandom);
    end
    idle(3);
    chk("random_saw_frames", 64'(fv_cnt > 6), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
